// File: rtl/dm_arbiter.sv
// Two-master arbiter for the single-port data memory with starvation counters.
// Optional round-robin tie-break when DMARB_RR_EN is defined.
module dm_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [2:0]    m0_dmtype,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [2:0]    m1_dmtype,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m0_stall,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic [2:0]    dm_dmtype,
  input  logic [DW-1:0] dm_dout
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait0, wait1;
  logic          sat0, sat1, pick1;
`ifdef DMARB_RR_EN
  logic          last_grant;
`endif

  assign sat0 = (wait0 == WMAX);
  assign sat1 = (wait1 == WMAX);

  // pick1 only matters when both masters request
  always_comb begin
    pick1 = 1'b0;
`ifdef DMARB_RR_EN
    if (sat1 && !sat0)
      pick1 = 1'b1;
    else if (sat0 || sat1)
      pick1 = 1'b0;
    else
      pick1 = ~last_grant;
`else
    pick1 = sat1 & ~sat0;
`endif
  end

  assign m0_gnt   = ~reset & m0_req & (~m1_req | ~pick1);
  assign m1_gnt   = ~reset & m1_req & (~m0_req | pick1);
  assign m0_stall = m0_req & ~m0_gnt;

  always_comb begin
    dm_we     = m0_gnt & m0_we;
    dm_addr   = m0_addr;
    dm_din    = m0_wdata;
    dm_dmtype = m0_dmtype;
    if (m1_gnt) begin
      dm_we     = m1_we;
      dm_addr   = m1_addr;
      dm_din    = m1_wdata;
      dm_dmtype = m1_dmtype;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait0     <= '0;
      wait1     <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      wait0     <= (m0_req && !m0_gnt) ? (sat0 ? wait0 : wait0 + 1'b1) : '0;
      wait1     <= (m1_req && !m1_gnt) ? (sat1 ? wait1 : wait1 + 1'b1) : '0;
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we)
        m0_rdata <= dm_dout;
      if (m1_gnt && !m1_we)
        m1_rdata <= dm_dout;
    end
  end

`ifdef DMARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= 1'b1;
    else if (m0_gnt)
      last_grant <= 1'b0;
    else if (m1_gnt)
      last_grant <= 1'b1;
  end
`endif

endmodule
